// File: rtl/spiral_pkg.sv
// Shared types for the spiral route scheduler: decision/consent codes, header layout, FSM states.
// No logic of its own; latency n/a.
// Backpressure n/a.
package spiral_pkg;

    localparam int HDR_W       = 50;
    localparam int ENT_LSB     = 0;
    localparam int CC_LSB      = 5;
    localparam int CONSENT_LSB = 8;
    localparam int FV_LSB      = 10;
    localparam int BASE_LSB    = 18;

    typedef enum logic [1:0] {
        DEC_ROUTE    = 2'b00,
        DEC_DELAY    = 2'b01,
        DEC_FALLBACK = 2'b10,
        DEC_BLOCK    = 2'b11
    } decision_t;

    typedef enum logic [1:0] {
        CONSENT_FULL       = 2'b00,
        CONSENT_DIMINISHED = 2'b01,
        CONSENT_SUSPENDED  = 2'b10,
        CONSENT_EMERGENCY  = 2'b11
    } consent_t;

    // Field order matches the lane bit layout, MSB first (base at BASE_LSB .. entropy at ENT_LSB).
    typedef struct packed {
        logic [31:0] base_address;
        logic [7:0]  fallback_vector;
        consent_t    consent_state;
        logic [2:0]  complecount;
        logic [4:0]  entropy;
    } hdr_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_OUT     = 2'b11
    } state_t;

    // Blocked headers never leak an address; fallback steers via the fallback vector.
    function automatic logic [31:0] resolve_address(input decision_t dec, input hdr_t hdr);
        logic [31:0] addr;
        case (dec)
            DEC_FALLBACK: addr = hdr.base_address ^ {24'b0, hdr.fallback_vector};
            DEC_BLOCK:    addr = 32'd0;
            default:      addr = hdr.base_address;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/spiral_rr_arbiter.sv
// Round-robin pick among masked requests, searching upward from ptr with wrap.
// Purely combinational, zero latency.
// No backpressure; grant is all-zero when no request is present.
module spiral_rr_arbiter #(
    parameter int NUM_REQ = 4
)(
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic found;
    int   cand;

    // First requester at or after ptr (mod NUM_REQ) wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spiral_route_scheduler.sv
// Time-shares one coherence evaluator across NUM_REQ header lanes and emits one routing decision per header.
// Latency: grant at t, evaluator enable at t+1, decision valid from t+3; next grant no earlier than t+5.
// Backpressure: decision held stable until dec_ready; no new header is accepted while a decision is pending.
module spiral_route_scheduler
    import spiral_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DELAY_BACKOFF = 8,
    parameter int CNT_W         = 16
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*50-1:0]        req_header,
    output logic                         eval_enable,
    output logic [4:0]                   eval_entropy,
    output logic [2:0]                   eval_complecount,
    input  logic [9:0]                   eval_score,
    input  logic                         eval_valid,
    input  logic                         etf_active,
    output logic                         dec_valid,
    input  logic                         dec_ready,
    output logic [1:0]                   dec_decision,
    output logic [$clog2(NUM_REQ)-1:0]   dec_requester,
    output logic [9:0]                   dec_score,
    output logic [31:0]                  dec_address,
    output logic                         busy,
    output logic [CNT_W-1:0]             blocked_count
);

    localparam int         IDX_W      = $clog2(NUM_REQ);
    localparam logic [3:0] BACKOFF_LD = 4'(DELAY_BACKOFF);

    state_t              state_q, state_d;
    logic                gap_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [IDX_W-1:0]    lane_q;
    hdr_t                hdr_q;
    hdr_t                lane_hdr [NUM_REQ];
    logic [3:0]          backoff_q [NUM_REQ];
    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  arb_req;
    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                any_grant;
    logic                accept;
    decision_t           dec_next;
    decision_t           dec_decision_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lane_hdr[i] = hdr_t'(req_header[i*HDR_W +: HDR_W]);
    end

    // Lanes serving a DELAY backoff sit out arbitration; the bubble cycle after a handoff grants nothing.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && (backoff_q[i] == 4'd0);
        end
        arb_req = (state_q == ST_IDLE && !gap_q) ? eligible : '0;
    end

    spiral_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (arb_req),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign any_grant = |grant;
    assign accept    = (state_q == ST_OUT) && dec_ready;

    // State register plus the one-cycle post-handoff bubble flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= accept;
        end
    end

    // Next-state: fixed walk through the evaluator, parked in OUT until the decision is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (any_grant) state_d = ST_ISSUE;
            ST_ISSUE:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_OUT;
            ST_OUT:     if (dec_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs; grant is already zero outside a grantable IDLE cycle.
    always_comb begin
        req_ready   = grant;
        eval_enable = (state_q == ST_ISSUE);
        dec_valid   = (state_q == ST_OUT);
        busy        = (state_q != ST_IDLE);
    end

    // Decision priority: freeze and withdrawn consent block outright, then evaluator validity, then throttling.
    always_comb begin
        dec_next = DEC_ROUTE;
        if (etf_active)
            dec_next = DEC_BLOCK;
        else if (hdr_q.consent_state == CONSENT_SUSPENDED || hdr_q.consent_state == CONSENT_EMERGENCY)
            dec_next = DEC_BLOCK;
        else if (!eval_valid)
            dec_next = DEC_FALLBACK;
        else if (hdr_q.consent_state == CONSENT_DIMINISHED)
            dec_next = DEC_DELAY;
    end

    // Header latch on grant, evaluator operands held, decision registered at CAPTURE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_q            <= '0;
            lane_q           <= '0;
            rr_ptr_q         <= '0;
            eval_entropy     <= '0;
            eval_complecount <= '0;
            dec_decision_q   <= DEC_ROUTE;
            dec_requester    <= '0;
            dec_score        <= '0;
            dec_address      <= '0;
        end else begin
            if (any_grant) begin
                hdr_q            <= lane_hdr[grant_idx];
                lane_q           <= grant_idx;
                rr_ptr_q         <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                eval_entropy     <= lane_hdr[grant_idx].entropy;
                eval_complecount <= lane_hdr[grant_idx].complecount;
            end
            if (state_q == ST_CAPTURE) begin
                dec_decision_q <= dec_next;
                dec_requester  <= lane_q;
                dec_score      <= eval_score;
                dec_address    <= resolve_address(dec_next, hdr_q);
            end
        end
    end

    assign dec_decision = dec_decision_q;

    // Per-lane backoff: reload on an accepted DELAY (overwriting any running count), else count down to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) backoff_q[i] <= 4'd0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept && lane_q == IDX_W'(i) && dec_decision_q == DEC_DELAY)
                    backoff_q[i] <= BACKOFF_LD;
                else if (backoff_q[i] != 4'd0)
                    backoff_q[i] <= backoff_q[i] - 4'd1;
            end
        end
    end

    // Saturating tally of BLOCK decisions actually handed downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            blocked_count <= '0;
        else if (accept && dec_decision_q == DEC_BLOCK && blocked_count != {CNT_W{1'b1}})
            blocked_count <= blocked_count + 1'b1;
    end

endmodule

// File: tb/tb_spiral_route_scheduler.sv
// Directed bench for spiral_route_scheduler with a behavioural stand-in for the coherence evaluator.
// Evaluator stand-in: score = 21*E + 3*C + (E!=0 ? 2 : 0), registered; valid when score >= 420.
// Counter width shrunk to 4 bits so saturation is reachable in a short run.
module tb_spiral_route_scheduler;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*50-1:0]  req_header;
    logic                   eval_enable;
    logic [4:0]             eval_entropy;
    logic [2:0]             eval_complecount;
    logic [9:0]             eval_score;
    logic                   eval_valid;
    logic                   etf_active;
    logic                   dec_valid;
    logic                   dec_ready;
    logic [1:0]             dec_decision;
    logic [1:0]             dec_requester;
    logic [9:0]             dec_score;
    logic [31:0]            dec_address;
    logic                   busy;
    logic [CNT_W-1:0]       blocked_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int gq_cyc[$];
    int gq_lane[$];
    int dq_dec[$];
    int dq_req[$];

    always #5 clk = ~clk;

    spiral_route_scheduler #(.NUM_REQ(NUM_REQ), .DELAY_BACKOFF(8), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_header       (req_header),
        .eval_enable      (eval_enable),
        .eval_entropy     (eval_entropy),
        .eval_complecount (eval_complecount),
        .eval_score       (eval_score),
        .eval_valid       (eval_valid),
        .etf_active       (etf_active),
        .dec_valid        (dec_valid),
        .dec_ready        (dec_ready),
        .dec_decision     (dec_decision),
        .dec_requester    (dec_requester),
        .dec_score        (dec_score),
        .dec_address      (dec_address),
        .busy             (busy),
        .blocked_count    (blocked_count)
    );

    // Evaluator stand-in
    logic [9:0] calc;
    always_comb calc = 10'(21 * int'(eval_entropy) + 3 * int'(eval_complecount) + ((eval_entropy != 0) ? 2 : 0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eval_score <= '0;
            eval_valid <= 1'b0;
        end else begin
            eval_valid <= eval_enable && (calc >= 10'd420);
            if (eval_enable) eval_score <= calc;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Grant / handoff recorder
    always @(negedge clk) begin
        #2;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                gq_cyc.push_back(cyc);
                gq_lane.push_back(i);
            end
        end
        if (dec_valid && dec_ready) begin
            dq_dec.push_back(int'(dec_decision));
            dq_req.push_back(int'(dec_requester));
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [49:0] mk_hdr(input logic [31:0] base, input logic [7:0] fv,
                                           input logic [1:0] consent, input logic [2:0] cc,
                                           input logic [4:0] ent);
        return {base, fv, consent, cc, ent};
    endfunction

    task automatic set_lane(input int idx, input logic [49:0] h);
        req_header[idx*50 +: 50] = h;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        dec_ready  = 1'b0;
        etf_active = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        gq_cyc.delete();
        gq_lane.delete();
        dq_dec.delete();
        dq_req.delete();
    endtask

    task automatic wait_dec(input string tag);
        int n = 0;
        while (!dec_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_dec_valid"}, dec_valid, 1'b1);
    endtask

    initial begin
        req_header = '0;
        rst_n      = 1'b0;
        req_valid  = '0;
        dec_ready  = 1'b0;
        etf_active = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_req_ready", req_ready, 4'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_dec_valid", dec_valid, 1'b0);
        check_eq("rst_eval_enable", eval_enable, 1'b0);
        check_eq("rst_blocked", blocked_count, 0);
        check_eq("rst_dec_address", dec_address, 0);

        // 1: lane0 E=31 C=7 full consent, exact cycle timing
        do_reset();
        set_lane(0, mk_hdr(32'h1000_0000, 8'h00, 2'b00, 3'd7, 5'd31));
        req_valid = 4'b0001;
        #1;
        check_eq("t1_req_ready_t", req_ready, 4'b0001);
        check_eq("t1_enable_t", eval_enable, 1'b0);
        @(negedge clk);
        req_valid = '0;
        check_eq("t1_enable_t1", eval_enable, 1'b1);
        check_eq("t1_entropy", eval_entropy, 5'd31);
        check_eq("t1_complecount", eval_complecount, 3'd7);
        check_eq("t1_busy", busy, 1'b1);
        @(negedge clk);
        check_eq("t1_enable_t2", eval_enable, 1'b0);
        check_eq("t1_dec_valid_t2", dec_valid, 1'b0);
        @(negedge clk);
        check_eq("t1_dec_valid_t3", dec_valid, 1'b1);
        check_eq("t1_decision", dec_decision, 2'b00);
        check_eq("t1_score", dec_score, 10'd674);
        check_eq("t1_addr", dec_address, 32'h1000_0000);
        check_eq("t1_requester", dec_requester, 2'd0);
        check_eq("t1_entropy_hold", eval_entropy, 5'd31);
        dec_ready = 1'b1;
        @(negedge clk);
        check_eq("t1_dec_valid_after", dec_valid, 1'b0);
        check_eq("t1_busy_after", busy, 1'b0);
        @(negedge clk);

        // 2: lane2 E=0 C=0 -> evaluator invalid -> fallback
        set_lane(2, mk_hdr(32'h1000_00A5, 8'h3C, 2'b00, 3'd0, 5'd0));
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        wait_dec("t2");
        check_eq("t2_decision", dec_decision, 2'b10);
        check_eq("t2_score", dec_score, 10'd0);
        check_eq("t2_addr", dec_address, 32'h1000_0099);
        check_eq("t2_requester", dec_requester, 2'd2);
        @(negedge clk);

        // 3: lane1 suspended consent -> block; counter saturates
        do_reset();
        set_lane(1, mk_hdr(32'h2000_1234, 8'h55, 2'b10, 3'd7, 5'd31));
        req_valid = 4'b0010;
        dec_ready = 1'b1;
        wait_dec("t3");
        check_eq("t3_decision", dec_decision, 2'b11);
        check_eq("t3_addr", dec_address, 32'd0);
        check_eq("t3_count_before", blocked_count, 0);
        @(negedge clk);
        check_eq("t3_count_after", blocked_count, 1);
        repeat (100) @(negedge clk);
        check_eq("t3_saturated", blocked_count, 4'hF);
        req_valid = '0;
        repeat (6) @(negedge clk);

        // 4: all lanes continuously valid -> 0,1,2,3,0 five cycles apart
        do_reset();
        for (int i = 0; i < NUM_REQ; i++)
            set_lane(i, mk_hdr(32'h3000_0000 + i, 8'h00, 2'b00, 3'd7, 5'd31));
        req_valid = 4'b1111;
        dec_ready = 1'b1;
        repeat (24) @(negedge clk);
        req_valid = '0;
        check_eq("t4_grant_count", gq_cyc.size() >= 5, 1'b1);
        if (gq_cyc.size() >= 5) begin
            for (int i = 0; i < 5; i++)
                check_eq($sformatf("t4_lane%0d", i), gq_lane[i], i % 4);
            for (int i = 1; i < 5; i++)
                check_eq($sformatf("t4_gap%0d", i), gq_cyc[i] - gq_cyc[i-1], 5);
        end
        repeat (6) @(negedge clk);

        // 5: lane1 diminished consent -> DELAY, lane1 masked 8 cycles, lane2 served meanwhile
        do_reset();
        set_lane(1, mk_hdr(32'h4000_0000, 8'h00, 2'b01, 3'd7, 5'd31));
        set_lane(2, mk_hdr(32'h5000_0000, 8'h00, 2'b00, 3'd7, 5'd31));
        req_valid = 4'b0110;
        dec_ready = 1'b1;
        repeat (17) @(negedge clk);
        req_valid = '0;
        repeat (6) @(negedge clk);
        check_eq("t5_grant_count", gq_cyc.size() >= 4, 1'b1);
        check_eq("t5_dec_count", dq_dec.size() >= 2, 1'b1);
        if (dq_dec.size() >= 2) begin
            check_eq("t5_lane1_req", dq_req[0], 1);
            check_eq("t5_lane1_delay", dq_dec[0], 1);
            check_eq("t5_lane2_route", dq_dec[1], 0);
        end
        if (gq_cyc.size() >= 4) begin
            check_eq("t5_g0", gq_lane[0], 1);
            check_eq("t5_g1", gq_lane[1], 2);
            check_eq("t5_g2", gq_lane[2], 2);
            check_eq("t5_g3", gq_lane[3], 1);
            check_eq("t5_g2_cyc", gq_cyc[2] - gq_cyc[0], 10);
            check_eq("t5_lane1_back", gq_cyc[3] - gq_cyc[0], 15);
        end

        // 6: ETF freeze blocks; decision held under backpressure; reset mid-flight
        do_reset();
        set_lane(0, mk_hdr(32'h6000_0000, 8'h11, 2'b00, 3'd7, 5'd31));
        etf_active = 1'b1;
        req_valid  = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        wait_dec("t6");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq($sformatf("t6_hold_valid%0d", i), dec_valid, 1'b1);
        end
        check_eq("t6_decision", dec_decision, 2'b11);
        check_eq("t6_addr", dec_address, 32'd0);
        check_eq("t6_score", dec_score, 10'd674);
        dec_ready = 1'b1;
        @(negedge clk);
        check_eq("t6_released", dec_valid, 1'b0);
        check_eq("t6_blocked", blocked_count, 1);
        etf_active = 1'b0;
        @(negedge clk);
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        check_eq("t6_issue", eval_enable, 1'b1);
        @(negedge clk);
        check_eq("t6_capture_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_busy", busy, 1'b0);
        check_eq("t6_rst_enable", eval_enable, 1'b0);
        check_eq("t6_rst_dec_valid", dec_valid, 1'b0);
        check_eq("t6_rst_blocked", blocked_count, 0);
        check_eq("t6_rst_entropy", eval_entropy, 5'd0);
        check_eq("t6_rst_decision", dec_decision, 2'b00);
        check_eq("t6_rst_req_ready", req_ready, 4'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("t6_dropped", dec_valid, 1'b0);
        check_eq("t6_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
